freq_sweep_seq: RTL

//  Sequences the DDS frequency word through a stepped sweep (learn mode) and schedules one amplitude

---
 rtl/freq_sweep_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/freq_sweep_seq.sv
// Stepped DDS frequency sweep: settles on each code, requests one amplitude
// measurement per point, and tracks the peak-response code.
module freq_sweep_seq #(
  parameter int unsigned SETTLE_CYC  = 2000,
  parameter int unsigned TIMEOUT_CYC = 5000000,
  parameter int unsigned CNT_W       = 12
) (
  input  logic             clk_50m,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      f_start,
  input  logic [15:0]      f_stop,
  input  logic [15:0]      f_step,
  input  logic [15:0]      f_restore,
  input  logic             meas_done,
  input  logic [15:0]      meas_amp,
  output logic [15:0]      freq_code,
  output logic             meas_start,
  output logic             busy,
  output logic             done,
  output logic [15:0]      peak_freq,
  output logic [15:0]      peak_amp,
  output logic [CNT_W-1:0] pt_cnt,
  output logic             timeout_err
);

  localparam int unsigned SET_W = (SETTLE_CYC  > 1) ? $clog2(SETTLE_CYC)  : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETTLE, MEAS_REQ, MEAS_WAIT, NEXT, FINISH
  } state_t;

  typedef struct packed {
    logic [15:0] f_start;
    logic [15:0] f_stop;
    logic [15:0] f_step;
    logic [15:0] f_restore;
  } sweep_cfg_t;

  state_t           state;
  sweep_cfg_t       cfg;
  logic [SET_W-1:0] settle_cnt;
  logic [TO_W-1:0]  wait_cnt;
  logic [16:0]      sum;

  // 17-bit so a step past 0xFFFF ends the sweep instead of wrapping
  assign sum = {1'b0, freq_code} + {1'b0, cfg.f_step};

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state       <= IDLE;
      cfg         <= '0;
      settle_cnt  <= '0;
      wait_cnt    <= '0;
      freq_code   <= '0;
      meas_start  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      peak_freq   <= '0;
      peak_amp    <= '0;
      pt_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      meas_start <= 1'b0;
      done       <= 1'b0;
      if (state != IDLE && abort) begin
        freq_code <= cfg.f_restore;
        busy      <= 1'b0;
        state     <= IDLE;
      end else begin
        case (state)
          IDLE: if (start && !abort) begin
            cfg.f_start   <= f_start;
            cfg.f_stop    <= f_stop;
            cfg.f_step    <= (f_step == 16'd0) ? 16'd1 : f_step;
            cfg.f_restore <= f_restore;
            peak_freq     <= '0;
            peak_amp      <= '0;
            pt_cnt        <= '0;
            timeout_err   <= 1'b0;
            busy          <= 1'b1;
            state         <= (f_start > f_stop) ? FINISH : LOAD;
          end
          LOAD: begin
            freq_code  <= cfg.f_start;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
          SETTLE: begin
            if (settle_cnt == SET_LAST) begin
              meas_start <= 1'b1;
              state      <= MEAS_REQ;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          MEAS_REQ: begin
            wait_cnt <= '0;
            state    <= MEAS_WAIT;
          end
          MEAS_WAIT: begin
            if (meas_done) begin
              if (pt_cnt != '1) pt_cnt <= pt_cnt + 1'b1;
              if (meas_amp > peak_amp) begin
                peak_amp  <= meas_amp;
                peak_freq <= freq_code;
              end
              state <= NEXT;
            end else if (wait_cnt == TO_LAST) begin
              // a timed-out point counts as amplitude 0, which never beats the peak
              if (pt_cnt != '1) pt_cnt <= pt_cnt + 1'b1;
              timeout_err <= 1'b1;
              state       <= NEXT;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          NEXT: begin
            if (sum[16] || sum[15:0] > cfg.f_stop) begin
              state <= FINISH;
            end else begin
              freq_code  <= sum[15:0];
              settle_cnt <= '0;
              state      <= SETTLE;
            end
          end
          FINISH: begin
            freq_code <= cfg.f_restore;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
